// File: rtl/axi_burst_read_master.sv
// AXI4 burst read master: turns a one-cycle read command into a single AR
// transaction, forwards R beats with one cycle of latency, queues one command.
module axi_burst_read_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BEATS  = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_read,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [31:0]           read_len,
  input  logic [2:0]            read_size,
  input  logic [1:0]            read_burst,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [DATA_WIDTH-1:0] rdata_out,
  output logic                  rvalid_out,
  output logic                  rlast_out,
  output logic                  busy,
  input  logic                  clear_errors,
  output logic                  resp_error,
  output logic                  last_mismatch,
  output logic                  len_error,
  output logic                  cmd_overflow
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    AR_ISSUE = 2'd1,
    R_DATA   = 2'd2
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      beat_cnt;

  logic                  pend_valid;
  logic [ADDR_WIDTH-1:0] pend_addr;
  logic [7:0]            pend_len;
  logic [2:0]            pend_size;
  logic [1:0]            pend_burst;

  logic                  len_ok;
  logic [7:0]            cmd_arlen;
  logic                  r_beat;
  logic                  cnt_one;
  logic                  end_beat;

  always_comb begin
    len_ok    = (read_len != 32'd0) && (read_len <= 32'(MAX_BEATS));
    cmd_arlen = 8'(read_len - 32'd1);
    r_beat    = (state == R_DATA) && rvalid && rready;
    cnt_one   = (beat_cnt == CNT_W'(1));
    end_beat  = r_beat && (cnt_one || rlast);
    busy      = (state != IDLE) || pend_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      beat_cnt      <= '0;
      araddr        <= '0;
      arlen         <= '0;
      arsize        <= '0;
      arburst       <= '0;
      arvalid       <= 1'b0;
      rready        <= 1'b0;
      rdata_out     <= '0;
      rvalid_out    <= 1'b0;
      rlast_out     <= 1'b0;
      pend_valid    <= 1'b0;
      pend_addr     <= '0;
      pend_len      <= '0;
      pend_size     <= '0;
      pend_burst    <= '0;
      resp_error    <= 1'b0;
      last_mismatch <= 1'b0;
      len_error     <= 1'b0;
      cmd_overflow  <= 1'b0;
    end else begin
      rvalid_out <= 1'b0;
      rlast_out  <= 1'b0;

      // Set events further down override this clear in the same cycle.
      if (clear_errors) begin
        resp_error    <= 1'b0;
        last_mismatch <= 1'b0;
        len_error     <= 1'b0;
        cmd_overflow  <= 1'b0;
      end

      case (state)
        IDLE: begin
        end

        AR_ISSUE: begin
          if (arready) begin
            arvalid  <= 1'b0;
            rready   <= 1'b1;
            beat_cnt <= CNT_W'(arlen) + CNT_W'(1);
            state    <= R_DATA;
          end
        end

        R_DATA: begin
          if (r_beat) begin
            rdata_out  <= rdata;
            rvalid_out <= 1'b1;
            rlast_out  <= end_beat;
            beat_cnt   <= beat_cnt - CNT_W'(1);
            if (rresp != 2'b00) begin
              resp_error <= 1'b1;
            end
            if (end_beat) begin
              rready <= 1'b0;
              if (cnt_one != rlast) begin
                last_mismatch <= 1'b1;
              end
              // Chain straight into the next AR so no IDLE bubble appears.
              if (pend_valid) begin
                araddr     <= pend_addr;
                arlen      <= pend_len;
                arsize     <= pend_size;
                arburst    <= pend_burst;
                arvalid    <= 1'b1;
                pend_valid <= 1'b0;
                state      <= AR_ISSUE;
              end else if (start_read && len_ok) begin
                araddr  <= read_addr;
                arlen   <= cmd_arlen;
                arsize  <= read_size;
                arburst <= read_burst;
                arvalid <= 1'b1;
                state   <= AR_ISSUE;
              end else begin
                state <= IDLE;
              end
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase

      if (start_read) begin
        if (!len_ok) begin
          len_error <= 1'b1;
        end else if (!pend_valid) begin
          if (state == IDLE) begin
            araddr  <= read_addr;
            arlen   <= cmd_arlen;
            arsize  <= read_size;
            arburst <= read_burst;
            arvalid <= 1'b1;
            state   <= AR_ISSUE;
          end else if (!end_beat) begin
            pend_valid <= 1'b1;
            pend_addr  <= read_addr;
            pend_len   <= cmd_arlen;
            pend_size  <= read_size;
            pend_burst <= read_burst;
          end
        end else begin
          cmd_overflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/axi_burst_read_master.md
Name: axi_burst_read_master

Overview:
- Sits between the block-based memory readers (noise-estimation and Wiener readers) and the AXI4 memory slave.
- Converts a single-cycle read command (start_read/read_addr/read_len/read_size/read_burst) into one AXI AR transaction, then collects the R beats.
- Forwards the beats to the reader and pixel consumer as registered rvalid/rlast/rdata strobes.
- Holds one pending command and reports protocol and length errors through sticky flags.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, R data width.
- MAX_BEATS, 256, largest legal read_len (AXI4 INCR limit).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start_read  in  1  command strobe, one cycle
- read_addr  in  ADDR_WIDTH  burst start address
- read_len  in  32  beat count (1..MAX_BEATS)
- read_size  in  3  AXI size code, passed to arsize
- read_burst  in  2  AXI burst type, passed to arburst
- araddr  out  ADDR_WIDTH  AR address
- arlen  out  8  AR length (beats-1)
- arsize  out  3  AR size
- arburst  out  2  AR burst
- arvalid  out  1  AR valid
- arready  in  1  AR ready
- rdata  in  DATA_WIDTH  R data
- rresp  in  2  R response
- rlast  in  1  R last from slave
- rvalid  in  1  R valid from slave
- rready  out  1  R ready
- rdata_out  out  DATA_WIDTH  beat to consumer
- rvalid_out  out  1  beat valid to reader/consumer
- rlast_out  out  1  final beat of burst
- busy  out  1  transaction or pending command outstanding
- clear_errors  in  1  synchronous clear of sticky flags
- resp_error  out  1  sticky: some beat had rresp != 0
- last_mismatch  out  1  sticky: slave rlast disagreed with beat count
- len_error  out  1  sticky: command with read_len 0 or > MAX_BEATS
- cmd_overflow  out  1  sticky: command dropped, pending slot full

Behaviour:
- Reset: every output is 0; state IDLE; pending slot empty; beat counter 0.
- States:
  - IDLE: no transaction.
  - AR_ISSUE: arvalid=1 with registered araddr/arlen/arsize/arburst.
  - R_DATA: rready=1.
- Command acceptance (any state):
  - start_read with an illegal length sets len_error and the command is discarded.
  - Otherwise, in IDLE with the pending slot empty: command registers; next cycle is AR_ISSUE (arvalid rises 1 cycle after start_read).
  - Otherwise, if the pending slot is empty: the command is stored there.
  - Otherwise: the command is dropped and cmd_overflow is set.
- arlen = read_len-1 (low 8 bits). AR fields stay stable while arvalid=1 and arready=0.
- AR_ISSUE -> R_DATA on the cycle arvalid && arready. arvalid drops the next cycle; beat counter loads read_len.
- R_DATA, each rvalid && rready beat:
  - next cycle: rdata_out=rdata, rvalid_out=1 (1-cycle latency, no backpressure to consumer).
  - counter decrements; rresp != 0 sets resp_error (data still forwarded).
- End of burst = the beat where counter==1 or slave rlast=1, whichever occurs first.
  - On that beat, rlast_out=1 with rvalid_out (next cycle).
  - last_mismatch is set if the slave rlast and counter==1 disagree on that beat.
  - rready drops the cycle after the end beat.
- After end of burst:
  - pending slot full: load it, clear the slot, go to AR_ISSUE.
  - else: go to IDLE.
- A start_read arriving on the same cycle as the end beat is accepted into the pending slot, which is empty at that point. It is issued directly after the end beat, with no IDLE cycle.
- rvalid_out, rlast_out: single-cycle pulses per beat. rdata_out holds its last value otherwise.
- busy = (state != IDLE) || pending full.
- clear_errors clears all sticky flags. A same-cycle error event wins (flag stays 1).
- Reset mid-transaction returns immediately to IDLE and discards the pending command. The slave must be reset alongside; no drain is performed.

Test Plan:
- Single burst: start_read, addr 0x1000, len 8, size 2, burst 1; arready 2 cycles late -> arvalid held 3 cycles with araddr 0x1000 and arlen 7; 8 rvalid_out pulses; rlast_out only on the 8th; return to IDLE; no flags set.
- Back-to-back: second start_read, addr 0x1008, issued while the first burst is streaming -> stored pending; arvalid for 0x1008 on the cycle after the first end beat; 16 total beats; busy low only after beat 16.
- Overflow: three commands while busy -> the third is dropped; cmd_overflow=1; only 2 AR transactions issued; clear_errors -> cmd_overflow=0.
- Length checks: read_len 0, then 257 -> len_error=1; no arvalid; busy stays 0.
- Slave errors: rresp=2 on beat 3 -> resp_error=1 and all 8 beats forwarded. Slave rlast on beat 6 of 8 -> rlast_out on beat 6, last_mismatch=1, return to IDLE.
- Reset mid-burst: assert rst_n low after beat 4 -> all outputs 0 immediately; a new command after release issues normally.
